fetch_unit: RTL and testbench

Parametrised instruction-fetch sequencer for the SLC-3 datapath. Owns PC, MAR, MDR and IR, and drives the SRAM control strobes through a multi-cycle read with a configurable number of wait states. Supports single-step (pause/continue) and free-running modes, plus PC redirect from the branch/jump logic. The ISDU consumes IR and the instr_valid pulse.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_if.sv | 18 +
 rtl/edge_detect.sv | 14 +
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the SLC-3 instruction-fetch sequencer.
//   fetch_state_t : sequencer state encoding
//   CNT_W         : width of the wait-state counter (covers WAIT_STATES up to 15)
//   PC_RESET      : program counter value after reset
package fetch_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, LOAD, PAUSE} fetch_state_t;
   localparam int CNT_W = 4;
   localparam logic [31:0] PC_RESET = '0;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: SRAM read bus between the fetch sequencer and memory.
//   mem_addr_o  : word address driven by the fetch unit
//   mem_ce_o    : active-low chip enable
//   mem_oe_o    : active-low output enable
//   mem_we_o    : active-low write enable (always high, read-only master)
//   mem_rdata_i : read data returned by memory
interface fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_ce_o;
   logic              mem_oe_o;
   logic              mem_we_o;
   logic [DATA_W-1:0] mem_rdata_i;
   modport master (output mem_addr_o, mem_ce_o, mem_oe_o, mem_we_o, input mem_rdata_i);
   modport slave (input mem_addr_o, mem_ce_o, mem_oe_o, mem_we_o, output mem_rdata_i);
endinterface

// File: rtl/edge_detect.sv
// edge_detect: registered 1-bit rising-edge detector.
//   clk, rst : clock and synchronous active-high reset
//   x_i      : level input
//   rise_o   : high while x_i is high and was low at the previous edge
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic x_i,
   output logic rise_o
);
   logic x_q;
   always_ff @(posedge clk) x_q <= rst ? 1'b0 : x_i;
   assign rise_o = x_i & ~x_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch sequencer owning PC, MAR, MDR and IR.
//   clk, rst        : clock and synchronous active-high reset
//   run_i           : start request (rising edge)
//   continue_i      : single-step request (rising edge)
//   pc_load_i       : redirect PC to pc_target_i, aborting a read in flight
//   pc_target_i     : redirect address
//   mem             : SRAM read bus (master side)
//   pc_o, ir_o      : program counter and instruction register
//   instr_valid_o   : one-cycle pulse after IR loads
//   busy_o          : high outside IDLE and PAUSE
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 20,
   parameter int WAIT_STATES = 2,
   parameter int PAUSE_EN    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_i,
   input  logic              continue_i,
   input  logic              pc_load_i,
   input  logic [DATA_W-1:0] pc_target_i,
   fetch_if.master           mem,
   output logic [DATA_W-1:0] pc_o,
   output logic [DATA_W-1:0] ir_o,
   output logic              instr_valid_o,
   output logic              busy_o
);
   fetch_state_t      state_q;
   logic [DATA_W-1:0] pc_q, mar_q, mdr_q, ir_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              valid_q, rd_n_q;
   logic              run_rise, cont_rise;

   edge_detect u_run (.clk(clk), .rst(rst), .x_i(run_i), .rise_o(run_rise));
   edge_detect u_cont (.clk(clk), .rst(rst), .x_i(continue_i), .rise_o(cont_rise));

   // rd_n_q is the registered read strobe: low exactly while state_q is WAIT or LATCH
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= PC_RESET[DATA_W-1:0];
         mar_q   <= '0;
         mdr_q   <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         rd_n_q  <= 1'b1;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: if (run_rise) state_q <= ADDR;
            ADDR: begin
               mar_q   <= pc_q;
               pc_q    <= pc_q + DATA_W'(1);
               cnt_q   <= '0;
               rd_n_q  <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WAIT_STATES - 1)) state_q <= LATCH;
            end
            LATCH: begin
               if (!pc_load_i) mdr_q <= mem.mem_rdata_i;
               rd_n_q  <= 1'b1;
               state_q <= LOAD;
            end
            LOAD: begin
               ir_q    <= mdr_q;
               valid_q <= 1'b1;
               state_q <= (PAUSE_EN != 0) ? PAUSE : ADDR;
            end
            PAUSE: if (cont_rise) state_q <= ADDR;
            default: state_q <= IDLE;
         endcase
         // redirect beats the ADDR increment; a read in flight is dropped and restarted
         if (pc_load_i) begin
            pc_q <= pc_target_i;
            if (state_q == WAIT || state_q == LATCH) begin
               state_q <= ADDR;
               rd_n_q  <= 1'b1;
            end
         end
      end
   end

   assign mem.mem_addr_o = {{(ADDR_W - DATA_W){1'b0}}, mar_q};
   assign mem.mem_ce_o   = rd_n_q;
   assign mem.mem_oe_o   = rd_n_q;
   assign mem.mem_we_o   = 1'b1;
   assign pc_o           = pc_q;
   assign ir_o           = ir_q;
   assign instr_valid_o  = valid_q;
   assign busy_o         = (state_q != IDLE) && (state_q != PAUSE);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (single-step and free-running instances).
module tb_fetch_unit;
   localparam int DW = 16;
   localparam int AW = 20;
   localparam int WS = 2;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] pc;
   } exp_t;

   typedef struct {
      logic        ld;
      logic [15:0] tgt;
      logic [15:0] exp_ir;
      logic [15:0] exp_pc;
   } vec_t;

   logic clk = 1'b0;
   logic rst, run, cont, pc_load, run_fr;
   logic [15:0] pc_target;
   logic [15:0] pc, ir, pc_fr, ir_fr;
   logic valid, busy, valid_fr, busy_fr;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int npulse = 0;
   int last_fr = -1;
   bit fr_on = 1'b0;
   exp_t sbq[$];
   logic [15:0] frq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
   fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fr ();

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: return 16'h1234;
         16'h0001: return 16'h5678;
         16'h0040: return 16'hABCD;
         default:  return a ^ 16'hC3A5;
      endcase
   endfunction

   // memory drives garbage unless OE is low, so a mistimed MDR latch is visible
   assign bus.mem_rdata_i    = bus.mem_oe_o ? 16'hDEAD : mem_word(bus.mem_addr_o[15:0]);
   assign bus_fr.mem_rdata_i = bus_fr.mem_oe_o ? 16'hDEAD : bus_fr.mem_addr_o[15:0];

   fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .PAUSE_EN(1)) dut (
      .clk(clk), .rst(rst), .run_i(run), .continue_i(cont), .pc_load_i(pc_load),
      .pc_target_i(pc_target), .mem(bus), .pc_o(pc), .ir_o(ir),
      .instr_valid_o(valid), .busy_o(busy)
   );

   fetch_unit #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS), .PAUSE_EN(0)) dut_fr (
      .clk(clk), .rst(rst), .run_i(run_fr), .continue_i(1'b0), .pc_load_i(1'b0),
      .pc_target_i(16'h0000), .mem(bus_fr), .pc_o(pc_fr), .ir_o(ir_fr),
      .instr_valid_o(valid_fr), .busy_o(busy_fr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input int n0, input string nm);
      for (int i = 0; i < 30 && npulse == n0; i++) step;
      chk(nm, npulse - n0, 1);
   endtask

   task automatic wait_strobe;
      for (int i = 0; i < 10 && bus.mem_ce_o; i++) step;
      chk("strobe_seen", bus.mem_ce_o, 1'b0);
   endtask

   // scoreboard for the single-step instance
   always @(negedge clk) begin
      if (valid) begin
         exp_t e;
         npulse++;
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid actual_ir=%h actual_pc=%h required=none", ir, pc);
         end else begin
            e = sbq.pop_front();
            chk("sb_ir", ir, e.ir);
            chk("sb_pc", pc, e.pc);
         end
      end
   end

   // scoreboard for the free-running instance
   always @(negedge clk) begin
      if (fr_on && valid_fr) begin
         logic [15:0] e;
         if (frq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL fr_unexpected_valid actual_ir=%h required=none", ir_fr);
         end else begin
            e = frq.pop_front();
            chk("fr_ir", ir_fr, e);
         end
         if (last_fr >= 0) chk("fr_spacing", cyc - last_fr, 3 + WS);
         last_fr = cyc;
      end
   end

   initial begin
      vec_t vec[6];
      int k, low_ce, low_oe, n0;
      bit got;
      vec[0] = '{1'b1, 16'h0010, mem_word(16'h0010), 16'h0011};
      vec[1] = '{1'b0, 16'h0000, mem_word(16'h0011), 16'h0012};
      vec[2] = '{1'b1, 16'h7FFF, mem_word(16'h7FFF), 16'h8000};
      vec[3] = '{1'b1, 16'hFFFF, mem_word(16'hFFFF), 16'h0000};
      vec[4] = '{1'b0, 16'h0000, 16'h1234, 16'h0001};
      vec[5] = '{1'b1, 16'h0001, 16'h5678, 16'h0002};
      run = 0; cont = 0; pc_load = 0; pc_target = 0; run_fr = 0; rst = 1;
      step; step;
      rst = 0;
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ce", bus.mem_ce_o, 1);
      chk("rst_oe", bus.mem_oe_o, 1);
      chk("rst_we", bus.mem_we_o, 1);
      chk("rst_addr", bus.mem_addr_o, 0);

      // first fetch: latency and strobe width
      sbq.push_back('{16'h1234, 16'h0001});
      run = 1;
      step;
      k = cyc; low_ce = 0; low_oe = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         step;
         if (!bus.mem_ce_o) low_ce++;
         if (!bus.mem_oe_o) low_oe++;
         if (valid) begin
            got = 1;
            chk("latency", cyc - k, 3 + WS);
         end
      end
      chk("fetch1_seen", got, 1);
      chk("ce_low_cycles", low_ce, WS + 1);
      chk("oe_low_cycles", low_oe, WS + 1);
      chk("we_high", bus.mem_we_o, 1);
      run = 0;
      step;
      chk("pause_busy", busy, 0);

      // Continue held high: exactly one step
      sbq.push_back('{16'h5678, 16'h0002});
      n0 = npulse;
      cont = 1;
      repeat (20) step;
      cont = 0;
      chk("cont_held_pulses", npulse - n0, 1);
      chk("cont_held_pc", pc, 16'h0002);
      chk("cont_held_ir", ir, 16'h5678);
      chk("cont_held_busy", busy, 0);

      // Run rise in PAUSE is ignored
      n0 = npulse;
      run = 1;
      repeat (10) step;
      run = 0;
      chk("run_in_pause_pulses", npulse - n0, 0);
      chk("run_in_pause_pc", pc, 16'h0002);

      // table-driven single steps with optional PC redirect in PAUSE
      for (int v = 0; v < 6; v++) begin
         if (vec[v].ld) begin
            pc_load = 1; pc_target = vec[v].tgt;
            step;
            pc_load = 0;
            chk("vec_preload_pc", pc, vec[v].tgt);
            chk("vec_preload_busy", busy, 0);
         end
         sbq.push_back('{vec[v].exp_ir, vec[v].exp_pc});
         n0 = npulse;
         cont = 1;
         step;
         cont = 0;
         wait_pulse(n0, "vec_pulse");
         chk("vec_busy", busy, 0);
      end

      // redirect in the second WAIT cycle aborts the fetch
      sbq.push_back('{16'hABCD, 16'h0041});
      n0 = npulse;
      cont = 1;
      step;
      cont = 0;
      wait_strobe;
      step;
      chk("abort_wait2_ce", bus.mem_ce_o, 0);
      pc_load = 1; pc_target = 16'h0040;
      step;
      pc_load = 0;
      chk("abort_ce", bus.mem_ce_o, 1);
      chk("abort_pc", pc, 16'h0040);
      chk("abort_valid", valid, 0);
      wait_pulse(n0, "abort_pulses");

      // reset in the middle of WAIT
      n0 = npulse;
      cont = 1;
      step;
      cont = 0;
      wait_strobe;
      rst = 1;
      step;
      rst = 0;
      chk("midrst_ce", bus.mem_ce_o, 1);
      chk("midrst_oe", bus.mem_oe_o, 1);
      chk("midrst_pc", pc, 0);
      chk("midrst_ir", ir, 0);
      chk("midrst_busy", busy, 0);
      repeat (10) step;
      chk("midrst_no_pulse", npulse - n0, 0);
      sbq.push_back('{16'h1234, 16'h0001});
      n0 = npulse;
      run = 1;
      step;
      run = 0;
      wait_pulse(n0, "refetch_pulse");

      // PC preset to 0xFFFF in IDLE, then Run: address and wrap
      rst = 1;
      step;
      rst = 0;
      pc_load = 1; pc_target = 16'hFFFF;
      step;
      pc_load = 0;
      chk("idle_preload_pc", pc, 16'hFFFF);
      chk("idle_preload_busy", busy, 0);
      sbq.push_back('{mem_word(16'hFFFF), 16'h0000});
      n0 = npulse;
      run = 1;
      step;
      run = 0;
      step;
      chk("wrap_addr", bus.mem_addr_o, 20'h0FFFF);
      chk("wrap_pc", pc, 16'h0000);
      chk("wrap_ce", bus.mem_ce_o, 0);
      wait_pulse(n0, "wrap_pulse");

      // free-running instance
      for (int i = 0; i < 4; i++) frq.push_back(16'(i));
      fr_on = 1;
      run_fr = 1;
      step;
      run_fr = 0;
      for (int i = 0; i < 100 && frq.size() > 0; i++) begin
         chk("fr_busy", busy_fr, 1);
         step;
      end
      chk("fr_done", frq.size(), 0);
      fr_on = 0;
      chk("sb_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
